// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the peripheral OBI arbiter: OBI request/response
// structs, arbiter FSM states and the watchdog response word.
package periph_arb_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hBADCAB1E;

  localparam int unsigned NHARTS_DEFAULT = 3;
  typedef logic [$clog2(NHARTS_DEFAULT)-1:0] hart_idx_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Owner index width; kept at least one bit wide.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/periph_rr_select.sv
// Combinational round-robin picker: first asserted request scanning from rr_ptr
// upwards, wrapping modulo NHARTS.
module periph_rr_select
  import periph_arb_pkg::*;
#(
  parameter int unsigned NHARTS = 3,
  parameter int unsigned IW     = idx_width(NHARTS)
) (
  input  logic [NHARTS-1:0] req,
  input  logic [IW-1:0]     rr_ptr,
  output logic [IW-1:0]     sel,
  output logic              valid
);

  logic [IW-1:0] cand;

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NHARTS; i++) begin
      cand = IW'((32'(rr_ptr) + i) % NHARTS);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        sel   = cand;
      end
    end
  end

endmodule

// File: rtl/periph_obi_arbiter.sv
// Round-robin arbiter sharing one OBI slave port between NHARTS masters, one
// outstanding transaction. Optional response watchdog: PERIPH_ARB_TIMEOUT_EN.
module periph_obi_arbiter
  import periph_arb_pkg::*;
#(
  parameter int unsigned NHARTS         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  master_req_i  [NHARTS],
  output obi_resp_t master_resp_o [NHARTS],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i
);

  localparam int unsigned IW = idx_width(NHARTS);

  if (NHARTS < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("periph_obi_arbiter: NHARTS and TIMEOUT_CYCLES must both be >= 2");
  end

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] lock_sel_q, lock_sel_d;
  logic          lock_q, lock_d;

  logic [NHARTS-1:0] req_vec;
  logic [IW-1:0]     rr_sel, sel;
  logic              rr_valid, sel_valid, issue;
  logic              rsp_fire, tmo_hit, issue_ok;
  logic [31:0]       rsp_rdata;

  always_comb begin
    req_vec = '0;
    for (int unsigned h = 0; h < NHARTS; h++) req_vec[h] = master_req_i[h].req;
  end

  periph_rr_select #(.NHARTS(NHARTS), .IW(IW)) u_rr_select (
    .req    (req_vec),
    .rr_ptr (rr_ptr_q),
    .sel    (rr_sel),
    .valid  (rr_valid)
  );

  // A stalled address phase keeps its master until granted, even if a
  // higher-priority master raises req meanwhile.
  assign sel       = lock_q ? lock_sel_q : rr_sel;
  assign sel_valid = lock_q ? req_vec[lock_sel_q] : rr_valid;
  assign issue     = (state_q == IDLE) && issue_ok && sel_valid;
  assign rsp_fire  = (state_q == WAIT_RSP) && (slave_resp_i.rvalid || tmo_hit);
  assign rsp_rdata = slave_resp_i.rvalid ? slave_resp_i.rdata : TIMEOUT_RDATA;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             stale_q, stale_d;

  assign tmo_hit  = (state_q == WAIT_RSP) && !slave_resp_i.rvalid &&
                    (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign issue_ok = !stale_q;

  // The late response of a timed-out transaction must not reach the next owner.
  always_comb begin
    tmo_cnt_d = '0;
    stale_d   = stale_q;
    if (state_q == WAIT_RSP) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    if (tmo_hit) stale_d = 1'b1;
    else if (state_q == IDLE && slave_resp_i.rvalid) stale_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
      stale_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      stale_q   <= stale_d;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign issue_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    lock_sel_d  = lock_sel_q;
    slave_req_o = '0;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          slave_req_o = master_req_i[sel];
          if (slave_resp_i.gnt) begin
            owner_d  = sel;
            rr_ptr_d = (sel == IW'(NHARTS - 1)) ? '0 : sel + IW'(1);
            lock_d   = 1'b0;
            state_d  = WAIT_RSP;
          end else begin
            lock_d     = 1'b1;
            lock_sel_d = sel;
          end
        end else begin
          lock_d = 1'b0;
        end
      end
      WAIT_RSP: begin
        if (rsp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned h = 0; h < NHARTS; h++) begin
      master_resp_o[h] = '0;
      if (issue && sel == IW'(h)) master_resp_o[h].gnt = slave_resp_i.gnt;
      if (rsp_fire && owner_q == IW'(h)) begin
        master_resp_o[h].rvalid = 1'b1;
        master_resp_o[h].rdata  = rsp_rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

endmodule

// File: tb/tb_periph_obi_arbiter.sv
// Self-checking bench for periph_obi_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_periph_obi_arbiter;
  import periph_arb_pkg::*;

  localparam int NH  = 3;
  localparam int TMO = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  obi_req_t  mreq  [NH];
  obi_resp_t mresp [NH];
  obi_req_t  sreq;
  obi_resp_t sresp;

  periph_obi_arbiter #(.NHARTS(NH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .master_req_i  (mreq),
    .master_resp_o (mresp),
    .slave_req_o   (sreq),
    .slave_resp_i  (sresp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one outstanding transaction, next owner is the first
  // requester after the last granted hart, stalled address phases stick.
  bit m_busy, m_stale;
  int m_owner, m_last, m_pending, m_wait;
  int gnt_hart, dut_gnt;
  obi_req_t  seen_sreq;
  obi_resp_t seen_resp [NH];
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic obi_req_t rand_req();
    obi_req_t r;
    r.req   = 1'b1;
    r.addr  = $urandom & 32'hFFFF_FFFC;
    r.we    = 1'($urandom_range(0, 1));
    r.be    = 4'($urandom_range(1, 15));
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_stale = 0; m_owner = 0; m_last = NH - 1; m_pending = -1; m_wait = 0;
  endtask

  // Called just after a negedge with inputs driven; checks and advances one cycle.
  task automatic cycle();
    int exp_sel;
    bit tmo_now;
    obi_req_t  exp_req;
    obi_resp_t exp_rsp;
    #1;
    seen_sreq = sreq;
    dut_gnt = -1;
    for (int h = 0; h < NH; h++) begin
      seen_resp[h] = mresp[h];
      if (mresp[h].gnt) dut_gnt = h;
    end
    exp_sel = -1;
    if (!m_busy && !m_stale) begin
      if (m_pending >= 0) begin
        if (mreq[m_pending].req) exp_sel = m_pending;
        else m_pending = -1;
      end else begin
        for (int k = 1; k <= NH; k++)
          if (exp_sel < 0 && mreq[(m_last + k) % NH].req) exp_sel = (m_last + k) % NH;
      end
    end
    tmo_now = 0;
`ifdef PERIPH_ARB_TIMEOUT_EN
    tmo_now = m_busy && !sresp.rvalid && (m_wait == TMO - 1);
`endif
    exp_req = '0;
    if (exp_sel >= 0) exp_req = mreq[exp_sel];
    check("slave_req", 70'(sreq), 70'(exp_req));
    for (int h = 0; h < NH; h++) begin
      exp_rsp = '0;
      if (h == exp_sel) exp_rsp.gnt = sresp.gnt;
      if (m_busy && h == m_owner && (sresp.rvalid || tmo_now)) begin
        exp_rsp.rvalid = 1'b1;
        exp_rsp.rdata  = sresp.rvalid ? sresp.rdata : 32'hBADCAB1E;
      end
      check($sformatf("resp%0d", h), 70'(mresp[h]), 70'(exp_rsp));
    end
    gnt_hart = -1;
    if (!m_busy) begin
      if (sresp.rvalid) m_stale = 0;
      if (exp_sel >= 0) begin
        if (sresp.gnt) begin
          m_busy = 1; m_owner = exp_sel; m_last = exp_sel; m_pending = -1; m_wait = 0;
          gnt_hart = exp_sel;
        end else begin
          m_pending = exp_sel;
        end
      end
    end else if (sresp.rvalid) begin
      m_busy = 0;
    end else if (tmo_now) begin
      m_busy = 0; m_stale = 1;
    end else begin
      m_wait++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int h = 0; h < NH; h++) mreq[h] = '0;
    sresp = '{gnt: 1'b1, rvalid: 1'b1, rdata: 32'hFFFF_FFFF};
    #1;
    check("rst_sreq", 70'(sreq), 70'(0));
    for (int h = 0; h < NH; h++) check($sformatf("rst_resp%0d", h), 70'(mresp[h]), 70'(0));
    @(negedge clk);
    @(negedge clk);
    sresp = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    for (int h = 0; h < NH; h++) mreq[h] = '0;
    sresp = '{gnt: 1'b0, rvalid: 1'b1, rdata: $urandom};
    cycle();
    sresp = '0;
  endtask

  initial begin
    obi_req_t hr;
    int got_k;
    rst_n = 1'b0;
    for (int h = 0; h < NH; h++) mreq[h] = '0;
    sresp = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset in the middle of WAIT_RSP, then a lone hart-1 request
    mreq[0] = rand_req(); sresp.gnt = 1'b1;
    cycle();
    mreq[0] = '0; sresp = '0;
    cycle();
    do_reset();
    hr = rand_req(); mreq[1] = hr; sresp.gnt = 1'b1;
    cycle();
    check("h1_gnt_after_rst", 70'(dut_gnt), 70'(1));
    check("h1_addr_after_rst", 70'(seen_sreq.addr), 70'(hr.addr));
    drain();

    // Fairness under continuous requests from all harts
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      for (int h = 0; h < NH; h++) if (!mreq[h].req) mreq[h] = rand_req();
      sresp.gnt = 1'b1; sresp.rvalid = m_busy; sresp.rdata = $urandom;
      cycle();
      if (gnt_hart >= 0) begin
        check("rr_order", 70'(dut_gnt), 70'(exp_q.pop_front()));
        mreq[gnt_hart] = '0;
      end
    end
    check("rr_order_done", 70'(exp_q.size()), 70'(0));
    drain();

    // Stalled hart-2 address phase holds while hart 0 raises req
    do_reset();
    hr = rand_req(); mreq[2] = hr; sresp = '0;
    cycle();
    mreq[0] = rand_req();
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("lock_addr", 70'(seen_sreq.addr), 70'(hr.addr));
    end
    sresp.gnt = 1'b1;
    cycle();
    check("lock_gnt_h2", 70'(dut_gnt), 70'(2));
    mreq[2] = '0;
    sresp = '{gnt: 1'b1, rvalid: 1'b1, rdata: $urandom};
    cycle();
    sresp.rvalid = 1'b0;
    cycle();
    check("lock_next_h0", 70'(dut_gnt), 70'(0));
    drain();

    // Hart 0 read routed only to hart 0
    mreq[0] = '{req: 1'b1, addr: 32'h0, we: 1'b0, be: 4'hF, wdata: 32'h0};
    sresp.gnt = 1'b1;
    cycle();
    mreq[0] = '0;
    sresp = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'h12345678};
    cycle();
    check("rd_h0_rvalid", 70'(seen_resp[0].rvalid), 70'(1));
    check("rd_h0_rdata", 70'(seen_resp[0].rdata), 70'(32'h12345678));
    check("rd_h1_rvalid", 70'(seen_resp[1].rvalid), 70'(0));
    check("rd_h2_rvalid", 70'(seen_resp[2].rvalid), 70'(0));

    // Spurious slave rvalid while idle
    sresp = '{gnt: 1'b0, rvalid: 1'b1, rdata: 32'hDEADBEEF};
    cycle();
    for (int h = 0; h < NH; h++) check($sformatf("spurious%0d", h), 70'(seen_resp[h].rvalid), 70'(0));
    sresp = '0;

`ifdef PERIPH_ARB_TIMEOUT_EN
    // Watchdog: no slave response, late rvalid dropped, then normal service
    do_reset();
    mreq[1] = rand_req(); sresp.gnt = 1'b1;
    cycle();
    mreq[1] = '0; sresp = '0;
    got_k = -1;
    for (int k = 1; k <= 20 && got_k < 0; k++) begin
      cycle();
      if (seen_resp[1].rvalid) begin
        got_k = k;
        check("tmo_rdata", 70'(seen_resp[1].rdata), 70'(32'hBADCAB1E));
      end
    end
    check("tmo_latency", 70'(got_k), 70'(8));
    mreq[0] = rand_req(); sresp.gnt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("stale_block", 70'(seen_sreq.req), 70'(0));
    end
    sresp = '{gnt: 1'b1, rvalid: 1'b1, rdata: 32'h55AA55AA};
    cycle();
    check("late_drop", 70'({seen_resp[0].rvalid, seen_resp[1].rvalid, seen_resp[2].rvalid}), 70'(0));
    sresp = '{gnt: 1'b1, rvalid: 1'b0, rdata: 32'h0};
    cycle();
    check("post_stale_gnt", 70'(dut_gnt), 70'(0));
    drain();
`endif

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int h = 0; h < NH; h++)
        if (!mreq[h].req && $urandom_range(0, 3) == 0) mreq[h] = rand_req();
      sresp.gnt   = ($urandom_range(0, 2) != 0);
      sresp.rdata = $urandom;
      if (m_busy) sresp.rvalid = 1'($urandom_range(0, 1));
      else if (m_stale) sresp.rvalid = ($urandom_range(0, 3) == 0);
      else sresp.rvalid = ($urandom_range(0, 19) == 0);
      cycle();
      if (gnt_hart >= 0) mreq[gnt_hart] = '0;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
